csa_result_accumulator: RTL

- Downstream consumer of the 8-bit carry-skip adder: takes each {carryout, Y} result as a 9-bit sample over a valid/ready handshake.
- Accumulates a programmed number of samples into a running total, then presents the total, the sample count and an overflow flag on an output handshake.
- Used by the FPGA lab datapath to reduce streams of adder results without a host in the loop.

---
 rtl/csa_result_accumulator.sv | 112 +++++++++++
 1 files changed

// File: rtl/csa_result_accumulator.sv
// csa_result_accumulator: collects {cout_in, sum_in} samples from the 8-bit
// carry-skip adder, sums a programmed number of them and hands the total,
// sample count and sticky overflow flag to a consumer over a valid/ready pair.
// Optional build macro: CSA_ACC_SATURATE_EN. When it is defined, the total
// clamps at all-ones on overflow. When it is undefined, the total wraps.
module csa_result_accumulator #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       sum_in,
  input  logic             cout_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] total,
  output logic [LEN_W-1:0] count,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] total_q, total_nx;
  logic [LEN_W-1:0] count_q, count_nx;
  logic [LEN_W-1:0] remain_q, remain_nx;
  logic             ovf_q, ovf_nx;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic             launch;

  // Sample is zero-extended to ACC_W+1 bits so the top bit is the carry out.
  assign sum_ext = {1'b0, total_q} + {{(ACC_W-8){1'b0}}, cout_in, sum_in};
  assign carry   = sum_ext[ACC_W];

  // A start is honoured in IDLE, or in DONE together with the result transfer.
  assign launch = start && ((state == IDLE) || ((state == DONE) && out_ready));

  // Next-state and datapath update.
  always_comb begin
    state_nx  = state;
    total_nx  = total_q;
    count_nx  = count_q;
    remain_nx = remain_q;
    ovf_nx    = ovf_q;
    case (state)
      IDLE: ;
      ACCUM: begin
        if (in_valid) begin
`ifdef CSA_ACC_SATURATE_EN
          total_nx = (carry || ovf_q) ? '1 : sum_ext[ACC_W-1:0];
`else
          total_nx = sum_ext[ACC_W-1:0];
`endif
          ovf_nx    = ovf_q | carry;
          count_nx  = count_q + LEN_W'(1);
          remain_nx = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // A launch overrides the plain IDLE/DONE transitions above.
    if (launch) begin
      total_nx  = '0;
      count_nx  = '0;
      ovf_nx    = 1'b0;
      remain_nx = len;
      state_nx  = (len != '0) ? ACCUM : DONE;
    end
  end

  // State and datapath registers; reset discards any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      total_q  <= '0;
      count_q  <= '0;
      remain_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      total_q  <= total_nx;
      count_q  <= count_nx;
      remain_q <= remain_nx;
      ovf_q    <= ovf_nx;
    end
  end

  // Handshake flags are pure decodes of the registered state.
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    total     = total_q;
    count     = count_q;
    ovf       = ovf_q;
  end

endmodule
